// File: rtl/exception_pkg.sv
// Shared types and helpers for the exception dispatch block.
// Optional nesting support is controlled by the NESTED_EXCEPTIONS_EN macro in exception_dispatch.
package exception_pkg;

    localparam int unsigned EXCEPTION_COUNT = 16;
    localparam int unsigned EXC_NUM_WIDTH   = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPATCH = 2'd1,
        ACTIVE   = 2'd2
    } dispatch_state_t;

    // Index of the lowest set bit (highest priority); 0 when the vector is empty.
    function automatic logic [EXC_NUM_WIDTH-1:0] lowest_set_index(
        input logic [EXCEPTION_COUNT-1:0] vec
    );
        logic [EXC_NUM_WIDTH-1:0] idx;
        idx = '0;
        for (int i = EXCEPTION_COUNT - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = EXC_NUM_WIDTH'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/exception_decoder.sv
// Combinational exception-number to one-hot decoder with enable.
module exception_decoder
    import exception_pkg::*;
(
    input  logic                       en_i,
    input  logic [EXC_NUM_WIDTH-1:0]   num_i,
    output logic [EXCEPTION_COUNT-1:0] onehot_o
);

    // One bit per exception source; all-zero when disabled.
    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[num_i] = 1'b1;
        end
    end

endmodule

// File: rtl/exception_dispatch.sv
// Exception dispatch: decodes the winning exception, redirects fetch to the
// handler vector via a valid/ready handshake, acknowledges the source and
// tracks handler lifetime until return.
// Define NESTED_EXCEPTIONS_EN to allow strictly-higher-priority preemption
// of an active handler; the default build is single-level.
module exception_dispatch
    import exception_pkg::*;
#(
    parameter int unsigned VECTOR_STRIDE_LOG2 = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       exceptionValid,
    input  logic [EXC_NUM_WIDTH-1:0]   exceptionNumber,
    input  logic                       globalEnable,
    input  logic [31:0]                vectorBase,
    input  logic                       dispatchReady,
    input  logic                       exceptionReturn,
    output logic                       vectorValid,
    output logic [31:0]                vectorAddress,
    output logic [EXCEPTION_COUNT-1:0] exceptionAck,
    output logic [EXCEPTION_COUNT-1:0] inService,
    output logic [EXC_NUM_WIDTH-1:0]   activeCause,
    output logic                       busy
);

    localparam int unsigned SLOT_LSB = VECTOR_STRIDE_LOG2 + EXC_NUM_WIDTH;

    dispatch_state_t            state_q;
    logic [EXC_NUM_WIDTH-1:0]   cause_q;
    logic                       vvalid_q;
    logic [31:0]                vaddr_q;
    logic [EXCEPTION_COUNT-1:0] ack_q;
    logic [EXCEPTION_COUNT-1:0] insvc_q;
    logic                       busy_q;

    logic                       accept_c;
    logic                       handshake_c;
    logic                       return_c;
    logic [31:0]                target_addr_c;
    logic [EXCEPTION_COUNT-1:0] set_mask_c;
    logic [EXCEPTION_COUNT-1:0] clr_mask_c;
    logic [EXCEPTION_COUNT-1:0] remain_c;
    logic                       unused_base_c;

    // Qualified events for the current state.
    assign accept_c    = (state_q == IDLE) && exceptionValid && globalEnable;
    assign handshake_c = (state_q == DISPATCH) && vvalid_q && dispatchReady;
    assign return_c    = (state_q == ACTIVE) && exceptionReturn;

    // Handler slot address for the incoming cause; base low bits are replaced.
    assign target_addr_c = {vectorBase[31:SLOT_LSB], exceptionNumber,
                            {VECTOR_STRIDE_LOG2{1'b0}}};
    assign unused_base_c = ^vectorBase[SLOT_LSB-1:0];

    // Set mask doubles as the ack pattern; clear mask retires the active cause.
    exception_decoder u_set_dec (
        .en_i     (handshake_c),
        .num_i    (cause_q),
        .onehot_o (set_mask_c)
    );

    exception_decoder u_clr_dec (
        .en_i     (return_c),
        .num_i    (cause_q),
        .onehot_o (clr_mask_c)
    );

    assign remain_c = insvc_q & ~clr_mask_c;

    // Dispatch FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cause_q  <= '0;
            vvalid_q <= 1'b0;
            vaddr_q  <= '0;
            ack_q    <= '0;
            insvc_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            ack_q <= '0;
            case (state_q)
                IDLE: begin
                    if (accept_c) begin
                        cause_q  <= exceptionNumber;
                        vvalid_q <= 1'b1;
                        vaddr_q  <= target_addr_c;
                        busy_q   <= 1'b1;
                        state_q  <= DISPATCH;
                    end
                end
                DISPATCH: begin
                    if (handshake_c) begin
                        vvalid_q <= 1'b0;
                        insvc_q  <= insvc_q | set_mask_c;
                        ack_q    <= set_mask_c;
                        state_q  <= ACTIVE;
                    end
                end
                ACTIVE: begin
`ifdef NESTED_EXCEPTIONS_EN
                    if (return_c) begin
                        insvc_q <= remain_c;
                        if (|remain_c) begin
                            cause_q <= lowest_set_index(remain_c);
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end else if (exceptionValid && globalEnable &&
                                 (exceptionNumber < cause_q)) begin
                        cause_q  <= exceptionNumber;
                        vvalid_q <= 1'b1;
                        vaddr_q  <= target_addr_c;
                        state_q  <= DISPATCH;
                    end
`else
                    if (return_c) begin
                        insvc_q <= remain_c;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
`endif
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign vectorValid   = vvalid_q;
    assign vectorAddress = vaddr_q;
    assign exceptionAck  = ack_q;
    assign inService     = insvc_q;
    assign activeCause   = cause_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_exception_dispatch.sv
// Directed self-checking bench for exception_dispatch.
module tb_exception_dispatch;

    logic        clk;
    logic        reset;
    logic        exceptionValid;
    logic [3:0]  exceptionNumber;
    logic        globalEnable;
    logic [31:0] vectorBase;
    logic        dispatchReady;
    logic        exceptionReturn;
    logic        vectorValid;
    logic [31:0] vectorAddress;
    logic [15:0] exceptionAck;
    logic [15:0] inService;
    logic [3:0]  activeCause;
    logic        busy;

    int checks = 0;
    int errors = 0;

    exception_dispatch #(.VECTOR_STRIDE_LOG2(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .exceptionValid  (exceptionValid),
        .exceptionNumber (exceptionNumber),
        .globalEnable    (globalEnable),
        .vectorBase      (vectorBase),
        .dispatchReady   (dispatchReady),
        .exceptionReturn (exceptionReturn),
        .vectorValid     (vectorValid),
        .vectorAddress   (vectorAddress),
        .exceptionAck    (exceptionAck),
        .inService       (inService),
        .activeCause     (activeCause),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_vv"},    32'(vectorValid),   32'h0);
        chk({tag, "_va"},    vectorAddress,      32'h0);
        chk({tag, "_ack"},   32'(exceptionAck),  32'h0);
        chk({tag, "_insvc"}, 32'(inService),     32'h0);
        chk({tag, "_cause"}, 32'(activeCause),   32'h0);
        chk({tag, "_busy"},  32'(busy),          32'h0);
    endtask

    initial begin
        reset           = 1'b1;
        exceptionValid  = 1'b0;
        exceptionNumber = 4'd0;
        globalEnable    = 1'b1;
        vectorBase      = 32'h0000_1000;
        dispatchReady   = 1'b0;
        exceptionReturn = 1'b0;
        step();
        step();
        chk_all_zero("rst");
        reset = 1'b0;

        // Basic dispatch of cause 5 with ready high.
        exceptionNumber = 4'd5;
        exceptionValid  = 1'b1;
        dispatchReady   = 1'b1;
        step();
        chk("t1_vv",    32'(vectorValid),  32'h1);
        chk("t1_va",    vectorAddress,     32'h0000_1050);
        chk("t1_busy",  32'(busy),         32'h1);
        chk("t1_noack", 32'(exceptionAck), 32'h0);
        chk("t1_cause", 32'(activeCause),  32'h5);
        exceptionValid = 1'b0;
        step();
        chk("t1_ack",   32'(exceptionAck), 32'h0020);
        chk("t1_insvc", 32'(inService),    32'h0020);
        chk("t1_busy2", 32'(busy),         32'h1);
        chk("t1_vvlow", 32'(vectorValid),  32'h0);
        step();
        chk("t1_ack1cy", 32'(exceptionAck), 32'h0);
        chk("t1_insvc2", 32'(inService),    32'h0020);

        // Return and new exception 3 in the same cycle: return wins.
        exceptionReturn = 1'b1;
        exceptionValid  = 1'b1;
        exceptionNumber = 4'd3;
        step();
        chk("t3_insvc", 32'(inService),   32'h0);
        chk("t3_busy",  32'(busy),        32'h0);
        chk("t3_vv",    32'(vectorValid), 32'h0);
        exceptionReturn = 1'b0;
        step();
        chk("t3_vv2",   32'(vectorValid), 32'h1);
        chk("t3_va",    vectorAddress,    32'h0000_1030);
        chk("t3_cause", 32'(activeCause), 32'h3);
        exceptionValid = 1'b0;
        step();
        chk("t3_ack",    32'(exceptionAck), 32'h0008);
        chk("t3_insvc2", 32'(inService),    32'h0008);
        exceptionReturn = 1'b1;
        step();
        exceptionReturn = 1'b0;
        chk("t3_ret_insvc", 32'(inService), 32'h0);
        chk("t3_ret_busy",  32'(busy),      32'h0);

        // Stalled handshake with cause 2; input changes ignored.
        dispatchReady   = 1'b0;
        exceptionNumber = 4'd2;
        exceptionValid  = 1'b1;
        step();
        chk("t2_vv_c0", 32'(vectorValid), 32'h1);
        chk("t2_va_c0", vectorAddress,    32'h0000_1020);
        exceptionNumber = 4'd9;
        vectorBase      = 32'h0000_2000;
        for (int c = 1; c < 3; c++) begin
            step();
            chk("t2_vv_stall",    32'(vectorValid),  32'h1);
            chk("t2_va_stall",    vectorAddress,     32'h0000_1020);
            chk("t2_ack_stall",   32'(exceptionAck), 32'h0);
            chk("t2_cause_stall", 32'(activeCause),  32'h2);
        end
        dispatchReady = 1'b1;
        step();
        chk("t2_ack",   32'(exceptionAck), 32'h0004);
        chk("t2_insvc", 32'(inService),    32'h0004);
        chk("t2_cause", 32'(activeCause),  32'h2);
        exceptionValid = 1'b0;
        vectorBase     = 32'h0000_1000;
        step();
        chk("t2_ack_off", 32'(exceptionAck), 32'h0);
        chk("t2_busy",    32'(busy),         32'h1);
        exceptionReturn = 1'b1;
        step();
        exceptionReturn = 1'b0;
        chk("t2_ret_busy", 32'(busy), 32'h0);

        // Acceptance gated by globalEnable; return in IDLE ignored.
        globalEnable    = 1'b0;
        exceptionValid  = 1'b1;
        exceptionNumber = 4'd4;
        step();
        step();
        chk("t4_vv",   32'(vectorValid), 32'h0);
        chk("t4_busy", 32'(busy),        32'h0);
        exceptionValid  = 1'b0;
        exceptionReturn = 1'b1;
        step();
        exceptionReturn = 1'b0;
        chk("t4_ret_busy",  32'(busy),        32'h0);
        chk("t4_ret_insvc", 32'(inService),   32'h0);
        chk("t4_ret_vv",    32'(vectorValid), 32'h0);
        globalEnable = 1'b1;

        // Cause 6 active, then lower-priority 7 and higher-priority 1.
        exceptionNumber = 4'd6;
        exceptionValid  = 1'b1;
        step();
        exceptionValid = 1'b0;
        step();
        chk("t5_insvc", 32'(inService),   32'h0040);
        chk("t5_cause", 32'(activeCause), 32'h6);
        exceptionNumber = 4'd7;
        exceptionValid  = 1'b1;
        step();
        chk("t5_hold7_vv",    32'(vectorValid), 32'h0);
        chk("t5_hold7_cause", 32'(activeCause), 32'h6);
        chk("t5_hold7_insvc", 32'(inService),   32'h0040);
        exceptionNumber = 4'd1;
        step();
`ifdef NESTED_EXCEPTIONS_EN
        chk("t5_pre_vv",    32'(vectorValid), 32'h1);
        chk("t5_pre_va",    vectorAddress,    32'h0000_1010);
        chk("t5_pre_cause", 32'(activeCause), 32'h1);
        chk("t5_pre_insvc", 32'(inService),   32'h0040);
        exceptionValid = 1'b0;
        step();
        chk("t5_nest_insvc", 32'(inService),    32'h0042);
        chk("t5_nest_ack",   32'(exceptionAck), 32'h0002);
        chk("t5_nest_cause", 32'(activeCause),  32'h1);
        exceptionReturn = 1'b1;
        step();
        exceptionReturn = 1'b0;
        chk("t5_ret1_cause", 32'(activeCause), 32'h6);
        chk("t5_ret1_insvc", 32'(inService),   32'h0040);
        chk("t5_ret1_busy",  32'(busy),        32'h1);
        step();
        exceptionReturn = 1'b1;
        step();
        exceptionReturn = 1'b0;
        chk("t5_ret2_insvc", 32'(inService), 32'h0);
        chk("t5_ret2_busy",  32'(busy),      32'h0);
`else
        chk("t5_hold1_vv",    32'(vectorValid), 32'h0);
        chk("t5_hold1_cause", 32'(activeCause), 32'h6);
        chk("t5_hold1_insvc", 32'(inService),   32'h0040);
        exceptionValid  = 1'b0;
        exceptionReturn = 1'b1;
        step();
        exceptionReturn = 1'b0;
        chk("t5_ret_insvc", 32'(inService), 32'h0);
        chk("t5_ret_busy",  32'(busy),      32'h0);
`endif

        // Reset during DISPATCH aborts without an ack.
        dispatchReady   = 1'b0;
        exceptionNumber = 4'd8;
        exceptionValid  = 1'b1;
        step();
        chk("t6_vv", 32'(vectorValid), 32'h1);
        chk("t6_va", vectorAddress,    32'h0000_1080);
        reset          = 1'b1;
        dispatchReady  = 1'b1;
        exceptionValid = 1'b0;
        step();
        chk_all_zero("t6_rst");
        reset = 1'b0;
        step();
        chk("t6_post_ack",  32'(exceptionAck), 32'h0);
        chk("t6_post_vv",   32'(vectorValid),  32'h0);
        chk("t6_post_busy", 32'(busy),         32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
